// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: computes a + b + c_in over DATA_W bits by reusing a single
// SLICE_W-bit adder slice for DATA_W/SLICE_W cycles, starting at the LSB. A
// registered carry links each slice to the next. Operands arrive and results
// leave over valid/ready handshakes.
module serial_adder_ctrl #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              c_out
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    // Refuse to elaborate when the operand does not split into whole slices
    if ((SLICE_W < 1) || (DATA_W < SLICE_W) || ((DATA_W % SLICE_W) != 0)) begin : g_width_check
        $error("serial_adder_ctrl: DATA_W (%0d) must be a positive multiple of SLICE_W (%0d)",
               DATA_W, SLICE_W);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  b_r;
    logic [DATA_W-1:0]  work;
    logic [DATA_W-1:0]  work_next;
    logic [DATA_W-1:0]  sum_r;
    logic               carry;
    logic               c_out_r;
    logic [IDX_W-1:0]   idx;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W:0]   slice_sum;
    logic               accept;
    logic               last_slice;

    assign accept     = (state == IDLE) && in_valid;
    assign last_slice = (state == RUN) && (idx == LAST_IDX);

    // Slice adder and the work word with the current slice merged in
    always_comb begin
        a_slice   = a_r[int'(idx) * SLICE_W +: SLICE_W];
        b_slice   = b_r[int'(idx) * SLICE_W +: SLICE_W];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE_W{1'b0}}, carry};
        work_next = work;
        work_next[int'(idx) * SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, step through slices, hold DONE until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: latch operands, ripple carry slice by slice, publish result
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            work    <= '0;
            sum_r   <= '0;
            carry   <= 1'b0;
            c_out_r <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            carry <= c_in;
            idx   <= '0;
        end else if (state == RUN) begin
            work  <= work_next;
            carry <= slice_sum[SLICE_W];
            if (last_slice) begin
                sum_r   <= work_next;
                c_out_r <= slice_sum[SLICE_W];
                idx     <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    assign sum   = sum_r;
    assign c_out = c_out_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vector table, multi-cycle corner sequences
// (output stall, reset abort) and a randomized run against a queue-based
// arithmetic reference model of a + b + c_in.
module tb_serial_adder_ctrl;

    localparam int DATA_W     = 16;
    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int NUM_RAND   = 200;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              c_in;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              c_out;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              c_in;
        logic [DATA_W-1:0] exp_sum;
        logic              exp_cout;
    } vec_t;

    vec_t vecs[6];

    serial_adder_ctrl #(
        .DATA_W  (DATA_W),
        .SLICE_W (SLICE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, reports a miscompare
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Bounded wait for the block to become ready, at a falling edge
    task automatic waitInReady();
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // Present one operand set, then scramble the inputs while it runs; returns
    // at the falling edge where out_valid is first seen, with the cycle count
    // (accept edge = cycle 0) in lat
    task automatic applyStimulus(input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb,
                                 input logic vc, output int lat);
        waitInReady();
        a        = va;
        b        = vb;
        c_in     = vc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 50) begin
            a    = DATA_W'($urandom);
            b    = DATA_W'($urandom);
            c_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int accepted;
        int completed;
        int cyc;
        logic [DATA_W:0] exp_val;
        logic [DATA_W:0] exp_q[$];
        logic never_valid;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset_busy",      32'(busy),      32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum",       32'(sum),       32'd0);
        checkOutput("reset_c_out",     32'(c_out),     32'd0);

        // Directed vector table with out_ready tied high
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b1;
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c_in, lat);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(NUM_SLICES + 1));
            checkOutput($sformatf("vec%0d_sum", i),     32'(sum), 32'(vecs[i].exp_sum));
            checkOutput($sformatf("vec%0d_c_out", i),   32'(c_out), 32'(vecs[i].exp_cout));
            checkOutput($sformatf("vec%0d_in_ready_done", i), 32'(in_ready), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
            checkOutput($sformatf("vec%0d_out_valid_after", i), 32'(out_valid), 32'd0);
            checkOutput($sformatf("vec%0d_sum_hold", i), 32'(sum), 32'(vecs[i].exp_sum));
        end

        // Consumer stalls for three cycles; new operands offered meanwhile are ignored
        out_ready = 1'b0;
        applyStimulus(16'h8000, 16'h8000, 1'b0, lat);
        checkOutput("stall_latency", 32'(lat), 32'(NUM_SLICES + 1));
        repeat (3) begin
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_sum",       32'(sum),       32'h0000);
            checkOutput("stall_c_out",     32'(c_out),     32'd1);
            checkOutput("stall_in_ready",  32'(in_ready),  32'd0);
            a        = 16'h1111;
            b        = 16'h2222;
            c_in     = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
        end
        checkOutput("stall_out_valid_end", 32'(out_valid), 32'd1);
        checkOutput("stall_sum_end",       32'(sum),       32'h0000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_in_ready",  32'(in_ready),  32'd1);
        checkOutput("stall_release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("stall_release_busy",      32'(busy),      32'd0);
        checkOutput("stall_release_sum",       32'({c_out, sum}), 32'h10000);

        // Reset in the second RUN cycle aborts the operation
        waitInReady();
        a        = 16'h00FF;
        b        = 16'h0001;
        c_in     = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("abort_busy_run", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_in_ready",  32'(in_ready), 32'd1);
        checkOutput("abort_busy",      32'(busy),     32'd0);
        checkOutput("abort_sum",       32'(sum),      32'h0000);
        never_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) never_valid = 1'b0;
            @(negedge clk);
        end
        checkOutput("abort_no_out_valid", 32'(never_valid), 32'd1);
        checkOutput("abort_sum_hold",     32'(sum),         32'h0000);
        applyStimulus(16'h0001, 16'h0001, 1'b0, lat);
        checkOutput("post_abort_sum",   32'({c_out, sum}), 32'h00002);
        @(negedge clk);

        // Randomized traffic against a queue of expected a + b + c_in results
        accepted  = 0;
        completed = 0;
        cyc       = 0;
        while (completed < NUM_RAND && cyc < 20000) begin
            a         = DATA_W'($urandom);
            b         = DATA_W'($urandom);
            c_in      = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (accepted < NUM_RAND) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (in_valid && in_ready) begin
                exp_q.push_back((DATA_W+1)'(a) + (DATA_W+1)'(b) + (DATA_W+1)'(c_in));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rand_spurious_result_pending", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_val = exp_q.pop_front();
                    checkOutput($sformatf("rand_result%0d", completed), 32'({c_out, sum}), 32'(exp_val));
                    completed++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("rand_completed",   32'(completed),    32'(NUM_RAND));
        checkOutput("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
